imem_arbiter: RTL and testbench

IMEM_ARBITER -- requirements
Module: imem_arbiter

---
 rtl/imem_arbiter_pkg.sv | 17 +
 rtl/imem_wait_counter.sv | 30 +++
 rtl/imem_arbiter.sv | 123 ++++++++++++
 tb/tb_imem_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_arbiter_pkg.sv
// Shared constants and FSM encoding for the instruction-memory arbiter.
// Any block that talks to the arbiter imports this package.
package imem_arbiter_pkg;

    localparam int ADDR_W          = 32;
    localparam int DATA_W          = 32;
    localparam int WADDR_W         = 30;
    localparam int CNT_W           = 4;
    localparam int WAIT_CYCLES_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DONE  = 2'd2
    } imem_state_e;

endpackage

// File: rtl/imem_wait_counter.sv
// Down-counter for the memory read latency.
// It is loaded when a fetch starts and holds at zero until the next load.
module imem_wait_counter
    import imem_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    output logic             zero
);

    logic [CNT_W-1:0] r_count;

    // Load on a fetch grant, otherwise count down to zero and stay there
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= {CNT_W{1'b0}};
        end else if (load) begin
            r_count <= value;
        end else if (r_count != {CNT_W{1'b0}}) begin
            r_count <= r_count - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_count <= r_count;
        end
    end

    assign zero = (r_count == {CNT_W{1'b0}});

endmodule

// File: rtl/imem_arbiter.sv
// Arbitrates one single-port instruction memory between the fetch stage and
// the program loader. Under contention the two requesters take turns.
module imem_arbiter
    import imem_arbiter_pkg::*;
#(
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               if_req,
    input  logic [ADDR_W-1:0]  if_addr,
    input  logic               branch_taken,
    output logic               if_freeze,
    output logic [DATA_W-1:0]  if_instr,
    output logic               if_valid,
    input  logic               ld_valid,
    input  logic [ADDR_W-1:0]  ld_addr,
    input  logic [DATA_W-1:0]  ld_data,
    output logic               ld_ready,
    output logic               mem_en,
    output logic               mem_we,
    output logic [WADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic [DATA_W-1:0]  mem_rdata
);

    localparam logic [CNT_W-1:0] LP_CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    imem_state_e        r_state;
    logic               r_pri_fetch;
    logic [WADDR_W-1:0] r_addr;
    logic [DATA_W-1:0]  r_instr;
    logic               r_valid;

    logic w_idle;
    logic w_fetch;
    logic w_ld_grant;
    logic w_if_grant;
    logic w_cnt_zero;
    logic w_unused_low;

    // Byte-lane bits of both addresses do not reach a word-addressed memory
    assign w_unused_low = ^{if_addr[1:0], ld_addr[1:0]};

    imem_wait_counter u_wait_counter (
        .clk   (clk),
        .reset (reset),
        .load  (w_if_grant),
        .value (LP_CNT_LOAD),
        .zero  (w_cnt_zero)
    );

    // Grant decode and memory/handshake drive; held at zero while in reset
    always_comb begin
        w_idle     = (r_state == ST_IDLE);
        w_fetch    = (r_state == ST_FETCH);
        w_ld_grant = !reset && w_idle && ld_valid && (!if_req || !r_pri_fetch);
        w_if_grant = !reset && w_idle && if_req && !w_ld_grant && !branch_taken;
        ld_ready   = w_ld_grant;
        if_freeze  = !reset && !branch_taken && ((w_idle && if_req) || w_fetch);
        if (w_ld_grant) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = ld_addr[ADDR_W-1:2];
            mem_wdata = ld_data;
        end else if (w_fetch && !reset) begin
            mem_en    = 1'b1;
            mem_we    = 1'b0;
            mem_addr  = r_addr;
            mem_wdata = {DATA_W{1'b0}};
        end else begin
            mem_en    = 1'b0;
            mem_we    = 1'b0;
            mem_addr  = {WADDR_W{1'b0}};
            mem_wdata = {DATA_W{1'b0}};
        end
    end

    // Arbiter FSM with registered instruction word and valid pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_pri_fetch <= 1'b0;
            r_addr      <= {WADDR_W{1'b0}};
            r_instr     <= {DATA_W{1'b0}};
            r_valid     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_valid <= 1'b0;
                    if (w_ld_grant) begin
                        r_pri_fetch <= 1'b1;
                    end else if (w_if_grant) begin
                        r_addr      <= if_addr[ADDR_W-1:2];
                        r_pri_fetch <= 1'b0;
                        r_state     <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (branch_taken) begin
                        r_state <= ST_IDLE;
                    end else if (w_cnt_zero) begin
                        r_instr <= mem_rdata;
                        r_valid <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_valid <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign if_instr = r_instr;
    assign if_valid = r_valid;

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a
// timeline-based reference model; a second instance covers the 1-cycle latency.
module tb_imem_arbiter;

    localparam int W  = 2;
    localparam int W1 = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, if_req, branch_taken, ld_valid;
    logic [31:0] if_addr, ld_addr, ld_data;
    logic        if_freeze, if_valid, ld_ready, mem_en, mem_we;
    logic [31:0] if_instr, mem_wdata, mem_rdata;
    logic [29:0] mem_addr;

    logic        b_reset, b_if_req;
    logic [31:0] b_if_addr;
    logic        b_if_freeze, b_if_valid, b_ld_ready, b_mem_en, b_mem_we;
    logic [31:0] b_if_instr, b_mem_wdata, b_mem_rdata;
    logic [29:0] b_mem_addr;

    logic [31:0] ram     [64];
    logic [31:0] ref_mem [64];

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    imem_arbiter #(.WAIT_CYCLES(W)) u_dut (
        .clk(clk), .reset(reset), .if_req(if_req), .if_addr(if_addr),
        .branch_taken(branch_taken), .if_freeze(if_freeze), .if_instr(if_instr),
        .if_valid(if_valid), .ld_valid(ld_valid), .ld_addr(ld_addr),
        .ld_data(ld_data), .ld_ready(ld_ready), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    imem_arbiter #(.WAIT_CYCLES(W1)) u_dut1 (
        .clk(clk), .reset(b_reset), .if_req(b_if_req), .if_addr(b_if_addr),
        .branch_taken(1'b0), .if_freeze(b_if_freeze), .if_instr(b_if_instr),
        .if_valid(b_if_valid), .ld_valid(1'b0), .ld_addr(32'h0000_0000),
        .ld_data(32'h0000_0000), .ld_ready(b_ld_ready), .mem_en(b_mem_en),
        .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata)
    );

    // Memory responders: read data is only good once the address has been held for the latency
    logic [29:0] p_addr, bp_addr;
    logic        p_rd = 1'b0, bp_rd = 1'b0;
    int          p_run = 0, bp_run = 0;
    int          cur_run, bcur_run;
    assign cur_run  = (p_rd && p_addr == mem_addr) ? p_run + 1 : 1;
    assign bcur_run = (bp_rd && bp_addr == b_mem_addr) ? bp_run + 1 : 1;
    assign mem_rdata   = (mem_en && !mem_we && cur_run >= W) ? ram[mem_addr[5:0]] : 32'hBAD0_BAD0;
    assign b_mem_rdata = (b_mem_en && !b_mem_we && bcur_run >= W1) ? ram[b_mem_addr[5:0]] : 32'hBAD0_BAD0;
    always @(posedge clk) begin
        p_rd  <= mem_en && !mem_we;   p_addr  <= mem_addr;   p_run  <= cur_run;
        bp_rd <= b_mem_en && !b_mem_we; bp_addr <= b_mem_addr; bp_run <= bcur_run;
    end

    // Reference model: a fetch granted in cycle c reads in c+1..c+W, delivers in c+W+1
    int          free_at = 0;
    int          fetch_t = 0;
    logic        m_pri = 1'b0;
    logic [29:0] m_addr = 30'd0;
    logic [31:0] m_last = 32'd0;
    bit          ld_acc = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        logic e_ldr = 1'b0, e_en = 1'b0, e_we = 1'b0, e_frz = 1'b0, e_val = 1'b0;
        logic [29:0] e_addr = 30'd0;
        logic [31:0] e_wd = 32'd0;
        if (reset) begin
            m_pri = 1'b0; m_last = 32'd0; free_at = 0;
        end else if (cyc >= free_at) begin
            if (ld_valid && (!if_req || !m_pri)) begin
                e_ldr = 1'b1; e_en = 1'b1; e_we = 1'b1;
                e_addr = ld_addr[31:2]; e_wd = ld_data;
                ref_mem[ld_addr[7:2]] = ld_data;
                m_pri = 1'b1;
            end else if (if_req && !branch_taken) begin
                m_addr = if_addr[31:2]; fetch_t = cyc; free_at = cyc + W + 2;
                m_pri = 1'b0;
            end
            e_frz = if_req && !branch_taken;
        end else if (cyc <= fetch_t + W) begin
            e_en = 1'b1; e_addr = m_addr; e_frz = !branch_taken;
            if (branch_taken) free_at = cyc + 1;
        end else begin
            e_val = 1'b1;
            m_last = ref_mem[m_addr[5:0]];
        end
        ld_acc = e_ldr;
        chk("ld_ready",  32'(ld_ready),  32'(e_ldr));
        chk("mem_en",    32'(mem_en),    32'(e_en));
        chk("mem_we",    32'(mem_we),    32'(e_we));
        chk("if_freeze", 32'(if_freeze), 32'(e_frz));
        chk("if_valid",  32'(if_valid),  32'(e_val));
        chk("if_instr",  if_instr,       m_last);
        if (e_en) chk("mem_addr", 32'(mem_addr), 32'(e_addr));
        if (e_we) chk("mem_wdata", mem_wdata, e_wd);
        if (mem_en === 1'b1 && mem_we === 1'b1) ram[mem_addr[5:0]] = mem_wdata;
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            ram[i] = $urandom;
            ref_mem[i] = ram[i];
        end
        reset = 1'b1; b_reset = 1'b1;
        if_req = 1'b0; branch_taken = 1'b0; ld_valid = 1'b0;
        if_addr = 32'd0; ld_addr = 32'd0; ld_data = 32'd0;
        b_if_req = 1'b0; b_if_addr = 32'd0;
        #1;
        tick();
        tick();
        reset = 1'b0; b_reset = 1'b0;

        // Contention right after reset: loader first, then strict alternation
        if_req = 1'b1; if_addr = 32'h0000_0014; ld_valid = 1'b1;
        ld_addr = 32'h0000_0080; ld_data = 32'hA5A5_0001;
        #1;
        chk("first_contend_loader", 32'(ld_ready), 32'd1);
        tick();
        ld_addr = 32'h0000_0084; ld_data = 32'hA5A5_0002;
        chk("alt_fetch_grant_no_ld", 32'(ld_ready), 32'd0);
        tick(); tick(); tick();
        chk("alt_fetch_delivers", 32'(if_valid), 32'd1);
        tick();
        chk("alt_second_loader", 32'(ld_ready), 32'd1);
        for (int i = 0; i < 10; i++) tick();
        if_req = 1'b0; ld_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();

        // Single fetch at 0x10 with no contention
        if_req = 1'b1; if_addr = 32'h0000_0010;
        #1;
        chk("fetch_freeze_c0", 32'(if_freeze), 32'd1);
        tick();
        if_req = 1'b0;
        #1;
        chk("fetch_addr_c1", 32'(mem_addr), 32'd4);
        tick();
        chk("fetch_addr_c2", 32'(mem_addr), 32'd4);
        tick();
        chk("fetch_valid_c3", 32'(if_valid), 32'd1);
        chk("fetch_word_c3", if_instr, ref_mem[4]);
        chk("fetch_nofreeze_c3", 32'(if_freeze), 32'd0);
        tick();

        // Loader write then fetch-back
        ld_valid = 1'b1; ld_addr = 32'h0000_0020; ld_data = 32'hE3A0_1005;
        #1;
        chk("load_ready", 32'(ld_ready), 32'd1);
        chk("load_we", 32'(mem_we), 32'd1);
        chk("load_addr", 32'(mem_addr), 32'd8);
        tick();
        ld_valid = 1'b0; if_req = 1'b1; if_addr = 32'h0000_0020;
        tick();
        if_req = 1'b0;
        tick(); tick();
        chk("readback_valid", 32'(if_valid), 32'd1);
        chk("readback_word", if_instr, 32'hE3A0_1005);
        tick();

        // Branch in the first FETCH cycle, then refetch from the new address
        if_req = 1'b1; if_addr = 32'h0000_0030;
        tick();
        branch_taken = 1'b1; if_addr = 32'h0000_0040;
        #1;
        chk("branch_freeze_low", 32'(if_freeze), 32'd0);
        tick();
        branch_taken = 1'b0;
        chk("branch_no_valid", 32'(if_valid), 32'd0);
        tick();
        if_req = 1'b0;
        chk("branch_new_addr", 32'(mem_addr), 32'h10);
        tick(); tick();
        chk("branch_refetch_word", if_instr, ref_mem[16]);
        tick();

        // Asynchronous reset in the middle of a fetch
        if_req = 1'b1; if_addr = 32'h0000_0008;
        tick();
        ld_valid = 1'b1; ld_addr = 32'h0000_0004; ld_data = 32'h1234_5678;
        reset = 1'b1;
        #1;
        chk("rst_freeze", 32'(if_freeze), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_ld_ready", 32'(ld_ready), 32'd0);
        chk("rst_instr", if_instr, 32'd0);
        tick();
        reset = 1'b0; ld_valid = 1'b0; if_addr = 32'h0000_000C;
        tick();
        if_req = 1'b0;
        tick(); tick();
        chk("post_rst_word", if_instr, ref_mem[3]);
        tick();

        // Random traffic; the loader holds its request until accepted
        for (int n = 0; n < 1500; n++) begin
            if (!ld_valid || ld_acc) begin
                ld_valid = ($urandom_range(0, 2) == 0);
                ld_addr  = {24'd0, 6'($urandom_range(0, 63)), 2'($urandom)};
                ld_data  = $urandom;
            end
            if_req       = 1'($urandom_range(0, 1));
            if_addr      = {24'd0, 6'($urandom_range(0, 63)), 2'($urandom)};
            branch_taken = ($urandom_range(0, 9) == 0);
            tick();
        end
        if_req = 1'b0; ld_valid = 1'b0; branch_taken = 1'b0;
        tick(); tick(); tick(); tick(); tick();

        // One-cycle latency instance: back-to-back fetches deliver every 3 cycles
        b_if_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            b_if_addr = 32'(k * 4);
            tick();
            chk("w1_gap", 32'(b_if_valid), 32'd0);
            tick();
            chk("w1_valid", 32'(b_if_valid), 32'd1);
            chk("w1_word", b_if_instr, ref_mem[k]);
            tick();
        end
        b_if_req = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
